// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/192/256 encryptor, one round per clock
// over a single shared round datapath, with valid/ready handshakes on both sides.
// Optional build macro AES_ENC_ABORT_EN adds an `abort` input that cancels an
// in-flight or completed-but-unread encryption.
module aes_encrypt_iter #(
    parameter int unsigned N  = 128,
    parameter int unsigned Nr = 10,
    parameter int unsigned Nk = 4
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_ENC_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    input  logic [N-1:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out,
    output logic         busy
);

    localparam int unsigned NumWords = 4 * (Nr + 1);
    localparam int unsigned KeyBits  = 128 * (Nr + 1);

    // Forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    // ------------------------------------------------------------------
    // Leaf operations
    // ------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] b);
        int unsigned idx;
        idx = 2047 - 8 * int'(b);
        return SboxTable[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // State is column-major: byte i sits at row i%4, column i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+row)%4)+row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    // Full key schedule, round key 0 in the top 128 bits.
    function automatic logic [KeyBits-1:0] key_expand(input logic [N-1:0] k);
        logic [31:0]        w [NumWords];
        logic [31:0]        t;
        logic [7:0]         rcon;
        logic [KeyBits-1:0] f;
        rcon = 8'h01;
        for (int i = 0; i < int'(NumWords); i++) begin
            if (i < int'(Nk)) begin
                w[i] = k[N-1-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % int'(Nk) == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xtime(rcon);
                end else if (Nk > 6 && i % int'(Nk) == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-int'(Nk)] ^ t;
            end
            f[KeyBits-1-32*i -: 32] = w[i];
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath
    // ------------------------------------------------------------------
    state_e         fsm_q;
    logic [3:0]     rnd_q;
    logic [127:0]   state_q;
    logic [N-1:0]   key_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [KeyBits-1:0] full_keys;
    logic [127:0]       round_key;
    logic [127:0]       sb_sr;
    logic [127:0]       mid_round;
    logic [127:0]       last_round;
    logic               abort_hit;

    assign full_keys  = key_expand(key_q);
    assign round_key  = full_keys[KeyBits - 1 - 128 * int'(rnd_q) -: 128];
    assign sb_sr      = shift_rows(sub_bytes(state_q));
    assign mid_round  = mix_columns(sb_sr) ^ round_key;
    assign last_round = sb_sr ^ round_key;

`ifdef AES_ENC_ABORT_EN
    assign abort_hit = abort && (fsm_q != StIdle);
`else
    assign abort_hit = 1'b0;
`endif

    // Control FSM with registered handshake outputs and the round state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            rnd_q       <= 4'd0;
            state_q     <= 128'h0;
            key_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (abort_hit) begin
            fsm_q       <= StIdle;
            rnd_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        // Round key 0 is the leading 128 key bits, so use key directly.
                        key_q      <= key;
                        state_q    <= in ^ key[N-1 -: 128];
                        rnd_q      <= 4'd1;
                        fsm_q      <= StRound;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                StRound: begin
                    if (rnd_q < 4'(Nr)) begin
                        state_q <= mid_round;
                        rnd_q   <= rnd_q + 4'd1;
                    end else begin
                        state_q     <= last_round;
                        fsm_q       <= StDone;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        fsm_q       <= StIdle;
                        rnd_q       <= 4'd0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out       = state_q;

endmodule
